calc_seq_ctrl: RTL and testbench
================================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles to wait for dp_done before declaring a timeout (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port locked, input, 1 bit: clock-manager lock; 0 forces idle.
REQ-005 SHALL have port btn, input, 1 bit: single-cycle, already-debounced "enter" pulse.
REQ-006 SHALL have port sw, input, 8 bits: operand entry switches.
REQ-007 SHALL have port func, input, 3 bits: operation select (0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 square).
REQ-008 SHALL have port dp_start, output, 1 bit: one-cycle datapath start strobe.
REQ-009 SHALL have ports dp_a and dp_b, output, 8 bits each, plus dp_func, output, 3 bits: the datapath operands and operation.
REQ-010 SHALL have port dp_done, input, 1 bit: one-cycle datapath completion strobe.
REQ-011 SHALL have port dp_result, input, 16 bits: datapath result, valid while dp_done is high.
REQ-012 SHALL have port result, output, 16 bits: the latched result for display.
REQ-013 SHALL have ports valid, output, 1 bit (result is meaningful), and err, output, 1 bit (error state).
REQ-014 SHALL have port err_code, output, 2 bits: 00 none, 01 divide-by-zero, 10 illegal func, 11 timeout.
REQ-015 SHALL have port phase, output, 3 bits: the current state encoding, used by the display.

Function
REQ-016 SHALL implement states IDLE, GET_B, CHECK, EXEC, WAIT, SHOW and ERR.
REQ-017 IDLE: on btn, SHALL capture sw into A and go to GET_B.
REQ-018 GET_B: on btn, SHALL capture sw into B and func into F, then go to CHECK.
REQ-019 CHECK (one cycle): if F is greater than 5, SHALL go to ERR with code 10.
REQ-020 CHECK: otherwise, if F is 3 or 4 and B is 0, SHALL go to ERR with code 01.
REQ-021 CHECK: otherwise SHALL go to EXEC.
REQ-022 EXEC: SHALL drive dp_start high for exactly one cycle, with dp_a, dp_b and dp_func stable from that cycle until WAIT exits, then go to WAIT.
REQ-023 For F = 5 (square), SHALL drive dp_b equal to A.
REQ-024 WAIT: on dp_done, SHALL latch dp_result into result, set valid to 1 and go to SHOW.
REQ-025 WAIT: SHALL count cycles spent in WAIT and, after TIMEOUT_CYCLES cycles without dp_done, go to ERR with code 11.
REQ-026 If dp_done and the timeout occur in the same cycle, dp_done SHALL take priority.
REQ-027 SHOW and ERR: on btn, SHALL clear result, valid, err and err_code, then go to IDLE.
REQ-028 SHALL ignore btn in CHECK, EXEC and WAIT.
REQ-029 SHALL ignore a dp_done that arrives in any state other than WAIT.
REQ-030 In ERR, err SHALL be 1 and result SHALL be 0.
REQ-031 While locked is 0, the next state SHALL be IDLE synchronously, with all registers cleared and dp_start held at 0.
REQ-032 A locked low pulse during WAIT SHALL abort the operation, and a later dp_done SHALL be ignored.
REQ-033 SHALL pass result through unaltered; subtraction results are 16-bit two's complement from the datapath.
REQ-034 Latency: SHALL assert dp_start 2 cycles after the GET_B btn, and assert valid 1 cycle after dp_done.

Reset
REQ-035 On rst_n low, SHALL asynchronously enter IDLE.
REQ-036 On rst_n low, SHALL clear A, B, F, result, the timeout counter, valid, err, err_code and dp_start to 0.
REQ-037 Reset during WAIT SHALL abort the operation with no dp_start reissued.

Structure
REQ-038 A shared package calc_pkg SHALL hold the func code constants and the err_code constants.
REQ-039 calc_pkg SHALL hold the state encoding used for phase.
REQ-040 calc_pkg SHALL hold the default TIMEOUT_CYCLES.
REQ-041 The design SHALL be a single module, with no sub-module required.
REQ-042 The verification environment SHALL provide a stub datapath, calc_dp_model, with programmable done latency.

Verification
REQ-043 Entry A=0x0C, B=0x05, func=2, done after 3 cycles -> dp_start once; dp_a=0x0C; dp_b=0x05; result=0x003C; valid=1; phase=SHOW.
REQ-044 A=0x07, B=0x00, func=3 -> no dp_start; err=1; err_code=01; a further btn returns to IDLE with all flags 0.
REQ-045 func=6 -> ERR with err_code=10; func=5 with A=0x10 -> dp_b=0x10 and result=0x0100.
REQ-046 Stub never asserts done, TIMEOUT_CYCLES=8 -> ERR with code 11 exactly 8 cycles after entering WAIT; done and timeout in the same cycle -> SHOW.
REQ-047 locked dropped for 1 cycle during WAIT -> IDLE; a late dp_done leaves valid=0.
REQ-048 rst_n pulsed mid-WAIT -> all outputs 0 immediately; btn during EXEC/WAIT has no effect.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: func codes, error codes,
// state encoding shown on the display, and the default datapath timeout.
package calc_pkg;

  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_MUL = 3'd2;
  localparam logic [2:0] FN_DIV = 3'd3;
  localparam logic [2:0] FN_MOD = 3'd4;
  localparam logic [2:0] FN_SQR = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_FUNC    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_B = 3'd1,
    S_CHECK = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_SHOW  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/calc_dp_model.sv
// Stub arithmetic datapath: captures operands on i_start and pulses o_done
// i_latency cycles later (i_latency = 0 means it never completes).
module calc_dp_model
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  input  logic [2:0]  i_func,
  input  logic [7:0]  i_latency,
  output logic        o_done,
  output logic [15:0] o_result
);

  logic [7:0]  r_cnt;
  logic [15:0] r_res;
  logic [15:0] w_calc;

  always_comb begin
    w_calc = '0;
    case (i_func)
      FN_ADD:         w_calc = 16'(i_a) + 16'(i_b);
      FN_SUB:         w_calc = 16'(i_a) - 16'(i_b);
      FN_MUL, FN_SQR: w_calc = 16'(i_a) * 16'(i_b);
      FN_DIV:         w_calc = (i_b != 8'd0) ? 16'(i_a / i_b) : '0;
      FN_MOD:         w_calc = (i_b != 8'd0) ? 16'(i_a % i_b) : '0;
      default:        w_calc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_res <= '0;
    end else if (i_start) begin
      r_cnt <= i_latency;
      r_res <= w_calc;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_done   = (r_cnt == 8'd1);
  assign o_result = r_res;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: collects two operands and a function via btn, checks
// them, launches the datapath, and latches its result or an error code.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        locked,
  input  logic        btn,
  input  logic [7:0]  sw,
  input  logic [2:0]  func,
  output logic        dp_start,
  output logic [7:0]  dp_a,
  output logic [7:0]  dp_b,
  output logic [2:0]  dp_func,
  input  logic        dp_done,
  input  logic [15:0] dp_result,
  output logic [15:0] result,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  phase
);

  state_e      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [2:0]  r_f;
  logic [15:0] r_result;
  logic [7:0]  r_cnt;
  logic        r_valid;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic        r_dp_start;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_f        <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_dp_start <= 1'b0;
    end else if (!locked) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_f        <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_dp_start <= 1'b0;
    end else begin
      r_dp_start <= 1'b0;
      case (r_state)
        S_IDLE: if (btn) begin
          r_a     <= sw;
          r_state <= S_GET_B;
        end
        S_GET_B: if (btn) begin
          r_b     <= sw;
          r_f     <= func;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (r_f > FN_SQR) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_FUNC;
            r_result   <= '0;
            r_state    <= S_ERR;
          end else if ((r_f == FN_DIV || r_f == FN_MOD) && r_b == 8'd0) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_DIV0;
            r_result   <= '0;
            r_state    <= S_ERR;
          end else begin
            // Registered strobe: high for the single cycle spent in EXEC.
            r_dp_start <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            r_result <= dp_result;
            r_valid  <= 1'b1;
            r_state  <= S_SHOW;
          end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_result   <= '0;
            r_state    <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SHOW, S_ERR: if (btn) begin
          r_result   <= '0;
          r_valid    <= 1'b0;
          r_err      <= 1'b0;
          r_err_code <= ERR_NONE;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Square reuses A as the second operand so the datapath only needs a multiplier.
  assign dp_b     = (r_f == FN_SQR) ? r_a : r_b;
  assign dp_a     = r_a;
  assign dp_func  = r_f;
  assign dp_start = r_dp_start;
  assign result   = r_result;
  assign valid    = r_valid;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign phase    = r_state;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboarded bench for calc_seq_ctrl: stimulus pushes expected datapath
// launches, results and errors; a negedge monitor pops and compares them.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        btn = 1'b0;
  logic [7:0]  sw = '0;
  logic [2:0]  func = '0;
  logic [7:0]  dp_lat = '0;
  logic        dp_start;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic [2:0]  dp_func;
  logic        dp_done;
  logic [15:0] dp_result;
  logic [15:0] result;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .btn(btn), .sw(sw), .func(func),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_func(dp_func),
    .dp_done(dp_done), .dp_result(dp_result), .result(result), .valid(valid),
    .err(err), .err_code(err_code), .phase(phase)
  );

  calc_dp_model u_dp (
    .clk(clk), .rst_n(rst_n), .i_start(dp_start), .i_a(dp_a), .i_b(dp_b),
    .i_func(dp_func), .i_latency(dp_lat), .o_done(dp_done), .o_result(dp_result)
  );

  typedef enum int {EV_START, EV_RESULT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] v0;     // dp_a for START, result for RESULT
    logic [15:0] v1;     // dp_b for START, err_code for ERR
    logic [2:0]  fn;
    int          delay;  // cycles after the last dp_start, -1 = not applicable
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   last_start = 0;
  logic prev_start = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      cyc++;
      if (dp_start) begin
        check("start_one_cycle", prev_start, 1'b0);
        last_start = cyc;
        check("start_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("start_kind", mon_e.kind, EV_START);
          check("dp_a", dp_a, mon_e.v0);
          check("dp_b", dp_b, mon_e.v1);
          check("dp_func", dp_func, mon_e.fn);
        end
      end
      if (valid && !prev_valid) begin
        check("result_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("result_kind", mon_e.kind, EV_RESULT);
          check("result", result, mon_e.v0);
          check("show_phase", phase, S_SHOW);
          check("result_latency", cyc - last_start, mon_e.delay);
        end
      end
      if (err && !prev_err) begin
        check("err_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("err_kind", mon_e.kind, EV_ERR);
          check("err_code", err_code, mon_e.v1);
          check("err_result_zero", result, 16'd0);
          check("err_phase", phase, S_ERR);
          if (mon_e.delay >= 0) check("timeout_latency", cyc - last_start, mon_e.delay);
        end
      end
      prev_start = dp_start;
      prev_valid = valid;
      prev_err   = err;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_calc(input int a, input int b, input int f);
    int r;
    case (f)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      3:       r = a / b;
      4:       r = a % b;
      default: r = a * a;
    endcase
    return r[15:0];
  endfunction

  task automatic expect_op(input int a, input int b, input int f, input int lat,
                           output logic [2:0] final_phase);
    exp_t e;
    e.fn = 3'(f);
    e.delay = -1;
    e.v0 = '0;
    e.v1 = '0;
    if (f > 5) begin
      e.kind = EV_ERR; e.v1 = 16'(ERR_FUNC); q.push_back(e); final_phase = S_ERR;
    end else if ((f == 3 || f == 4) && b == 0) begin
      e.kind = EV_ERR; e.v1 = 16'(ERR_DIV0); q.push_back(e); final_phase = S_ERR;
    end else begin
      e.kind = EV_START; e.v0 = 16'(a); e.v1 = (f == 5) ? 16'(a) : 16'(b);
      q.push_back(e);
      if (lat == 0 || lat > TO) begin
        e.kind = EV_ERR; e.v0 = '0; e.v1 = 16'(ERR_TIMEOUT); e.delay = TO + 1;
        final_phase = S_ERR;
      end else begin
        e.kind = EV_RESULT; e.v0 = ref_calc(a, b, f); e.v1 = '0; e.delay = lat + 1;
        final_phase = S_SHOW;
      end
      q.push_back(e);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] s, input logic [2:0] f);
    sw = s; func = f; btn = 1'b1;
    step();
    btn = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p0, input logic [2:0] p1, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (phase == p0 || phase == p1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic run_op(input int a, input int b, input int f, input int lat, input bit noise);
    logic [2:0] fp;
    bit ok;
    dp_lat = 8'(lat);
    expect_op(a, b, f, lat, fp);
    press(8'(a), 3'($urandom));
    press(8'(b), 3'(f));
    if (noise) begin
      btn = 1'b1;  // held through CHECK and EXEC, must be ignored
      step();
      step();
      btn = 1'b0;
    end
    wait_phase(S_SHOW, S_ERR, 4 * TO + 40, ok);
    check("op_finished", ok, 1'b1);
    check("final_phase", phase, fp);
    press(8'($urandom), 3'd0);
    check("cleared_after_btn", {result, valid, err, err_code, phase}, 23'd0);
  endtask

  task automatic start_long_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    exp_t e;
    bit ok;
    dp_lat = 8'd20;
    e.kind = EV_START; e.v0 = 16'(a); e.v1 = 16'(b); e.fn = f; e.delay = -1;
    q.push_back(e);
    press(a, 3'd0);
    press(b, f);
    wait_phase(S_WAIT, S_WAIT, 10, ok);
    check("reached_wait", ok, 1'b1);
    step();
  endtask

  initial begin
    #1;
    check("reset_outputs", {dp_start, result, valid, err, err_code, phase}, 24'd0);
    repeat (2) step();
    rst_n = 1'b1;
    press(8'h55, 3'd0);
    check("unlocked_stays_idle", phase, S_IDLE);
    locked = 1'b1;
    step();

    run_op(8'h0C, 8'h05, 2, 3, 1'b0);   // multiply, done after 3 cycles
    run_op(8'h07, 8'h00, 3, 3, 1'b0);   // divide by zero
    run_op(8'h07, 8'h00, 4, 3, 1'b0);   // modulo by zero
    run_op(8'h07, 8'h02, 6, 3, 1'b0);   // illegal func
    run_op(8'h10, 8'h99, 5, 2, 1'b0);   // square ignores B
    run_op(8'h03, 8'h09, 1, 1, 1'b1);   // negative subtraction, btn noise
    run_op(8'hFF, 8'hFF, 0, 4, 1'b0);   // add with carry out
    run_op(8'h21, 8'h05, 2, 0, 1'b0);   // datapath never completes
    run_op(8'h21, 8'h05, 2, TO, 1'b0);  // done coincides with timeout
    run_op(8'h21, 8'h05, 2, TO + 1, 1'b0);

    start_long_op(8'h33, 8'h44, 3'd0);
    locked = 1'b0;
    step();
    locked = 1'b1;
    check("lock_drop_outputs", {result, valid, err, err_code, phase}, 23'd0);
    repeat (30) step();
    check("late_done_valid", valid, 1'b0);
    check("late_done_phase", phase, S_IDLE);

    start_long_op(8'h12, 8'h34, 3'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {dp_start, result, valid, err, err_code, phase}, 24'd0);
    step();
    rst_n = 1'b1;
    repeat (30) step();
    check("after_reset_idle", {valid, phase}, 4'd0);

    for (int i = 0; i < 40; i++) begin
      int a, b, f, lat;
      bit legal;
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
      f = $urandom_range(0, 7);
      lat = $urandom_range(0, TO + 2);
      legal = (f <= 5) && !((f == 3 || f == 4) && b == 0);
      run_op(a, b, f, lat, legal && ($urandom_range(0, 1) == 1));
    end

    repeat (3) step();
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
